// File: rtl/hamming_secded_pipe.sv
// Streaming extended-Hamming SEC-DED encoder / error injector / decoder.
// Three registered stages (encode, syndrome, correct) with valid/ready flow control and saturating error counters.
module hamming_secded_pipe #(
  parameter int DATA_W = 4,
  parameter int SECDED = 1,
  parameter int CNT_W  = 8,
  localparam int P     = (DATA_W <= 1)  ? 2 :
                         (DATA_W <= 4)  ? 3 :
                         (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 : 6,
  localparam int N     = DATA_W + P,
  localparam int CW_W  = N + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CW_W-1:0]   in_inject,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW_W-1:0]   out_codeword,
  output logic [P-1:0]      out_syndrome,
  output logic              out_err_single,
  output logic              out_err_double,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  function automatic logic is_data_pos(input int i);
    return ((i & (i - 1)) != 0);
  endfunction

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    logic            par;
    int              j;
    cw = '0;
    j  = 0;
    for (int i = 1; i <= N; i++) begin
      if (is_data_pos(i)) begin
        cw[i] = d[j];
        j     = j + 1;
      end
    end
    for (int k = 0; k < P; k++) begin
      par = 1'b0;
      for (int i = 1; i <= N; i++) begin
        if (is_data_pos(i) && (((i >> k) & 1) != 0)) par = par ^ cw[i];
      end
      cw[1 << k] = par;
    end
    if (SECDED != 0) cw[0] = ^cw[N:1];
    else             cw[0] = 1'b0;
    return cw;
  endfunction

  function automatic logic [P-1:0] syndrome(input logic [CW_W-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int i = 1; i <= N; i++) begin
      if (cw[i]) s = s ^ P'(i);
    end
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int                j;
    d = '0;
    j = 0;
    for (int i = 1; i <= N; i++) begin
      if (is_data_pos(i)) begin
        d[j] = cw[i];
        j    = j + 1;
      end
    end
    return d;
  endfunction

  logic              s1_valid_r, s2_valid_r;
  logic [CW_W-1:0]   s1_cw_r, s2_cw_r;
  logic [P-1:0]      s2_syn_r;
  logic              s2_q_r;
  logic              s3_load_s, s2_load_s, s1_load_s, out_fire_s;
  logic [CW_W-1:0]   corr_cw_s;
  logic              single_s, double_s;

  // A stage may load when the stage after it is empty or draining this cycle.
  assign out_fire_s = out_valid & out_ready;
  assign s3_load_s  = s2_valid_r & (~out_valid | out_ready);
  assign s2_load_s  = s1_valid_r & (~s2_valid_r | s3_load_s);
  assign s1_load_s  = in_valid & in_ready;
  assign in_ready   = ~s1_valid_r | s2_load_s;

  // Decode: classify the syndrome/parity pair and flip the indicated bit.
  always_comb begin
    corr_cw_s = s2_cw_r;
    single_s  = 1'b0;
    double_s  = 1'b0;
    if (s2_syn_r == '0) begin
      if ((SECDED != 0) && s2_q_r) single_s = 1'b1;
      else                          single_s = 1'b0;
    end else if ((32'(s2_syn_r) <= N) && ((SECDED == 0) || s2_q_r)) begin
      single_s = 1'b1;
      for (int i = 1; i <= N; i++) begin
        if (32'(s2_syn_r) == i) corr_cw_s[i] = ~s2_cw_r[i];
      end
    end else begin
      double_s = 1'b1;
    end
  end

  // Encode and syndrome stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_cw_r    <= '0;
      s2_valid_r <= 1'b0;
      s2_cw_r    <= '0;
      s2_syn_r   <= '0;
      s2_q_r     <= 1'b0;
    end else begin
      if (s1_load_s)     s1_valid_r <= 1'b1;
      else if (s2_load_s) s1_valid_r <= 1'b0;
      if (s1_load_s) s1_cw_r <= encode(in_data) ^ in_inject;
      if (s2_load_s)      s2_valid_r <= 1'b1;
      else if (s3_load_s) s2_valid_r <= 1'b0;
      if (s2_load_s) begin
        s2_cw_r  <= s1_cw_r;
        s2_syn_r <= syndrome(s1_cw_r);
        s2_q_r   <= ^s1_cw_r;
      end
    end
  end

  // Output stage: holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_codeword   <= '0;
      out_syndrome   <= '0;
      out_err_single <= 1'b0;
      out_err_double <= 1'b0;
    end else begin
      if (s3_load_s) begin
        out_valid      <= 1'b1;
        out_data       <= extract(corr_cw_s);
        out_codeword   <= s2_cw_r;
        out_syndrome   <= s2_syn_r;
        out_err_single <= single_s;
        out_err_double <= double_s;
      end else if (out_fire_s) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Saturating counters of delivered error beats; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire_s) begin
      if (out_err_single && (corr_cnt != '1))   corr_cnt   <= corr_cnt + 1'b1;
      if (out_err_double && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Directed bench for hamming_secded_pipe: vector table on a DATA_W=4/CNT_W=2 instance,
// plus backpressure, saturation/clear, DATA_W=8 out-of-range syndrome and mid-stream reset sequences.
module tb_hamming_secded_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic [3:0]  in_data, out_data;
  logic [7:0]  in_inject, out_codeword;
  logic [2:0]  out_syndrome;
  logic        out_err_single, out_err_double;
  logic [1:0]  corr_cnt, uncorr_cnt;

  logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, clr_cnt_8;
  logic [7:0]  in_data_8, out_data_8;
  logic [12:0] in_inject_8, out_codeword_8;
  logic [3:0]  out_syndrome_8;
  logic        out_err_single_8, out_err_double_8;
  logic [7:0]  corr_cnt_8, uncorr_cnt_8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_secded_pipe #(.DATA_W(4), .SECDED(1), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inject(in_inject), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_codeword(out_codeword),
    .out_syndrome(out_syndrome), .out_err_single(out_err_single),
    .out_err_double(out_err_double), .clr_cnt(clr_cnt), .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );

  hamming_secded_pipe #(.DATA_W(8), .SECDED(1), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .in_data(in_data_8), .in_inject(in_inject_8), .out_valid(out_valid_8),
    .out_ready(out_ready_8), .out_data(out_data_8), .out_codeword(out_codeword_8),
    .out_syndrome(out_syndrome_8), .out_err_single(out_err_single_8),
    .out_err_double(out_err_double_8), .clr_cnt(clr_cnt_8), .corr_cnt(corr_cnt_8),
    .uncorr_cnt(uncorr_cnt_8)
  );

  typedef struct {
    logic [3:0] data;
    logic [7:0] inj;
    logic       clr;
    logic [7:0] cw;
    logic [3:0] dout;
    logic [2:0] syn;
    logic       single;
    logic       dbl;
    logic [1:0] corr;
    logic [1:0] uncorr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = v.data;
    in_inject = v.inj;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_cw"}, 32'(out_codeword), 32'(v.cw));
    chk({tag, "_data"}, 32'(out_data), 32'(v.dout));
    chk({tag, "_syn"}, 32'(out_syndrome), 32'(v.syn));
    chk({tag, "_single"}, 32'(out_err_single), 32'(v.single));
    chk({tag, "_double"}, 32'(out_err_double), 32'(v.dbl));
    clr_cnt = v.clr;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    chk({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(v.corr));
    chk({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'(v.uncorr));
  endtask

  task automatic run8(input logic [7:0] d, input logic [12:0] m, input logic [12:0] ecw,
                      input logic [3:0] esyn, input logic es, input logic ed,
                      input logic [7:0] ecorr, input logic [7:0] euncorr, input string tag);
    int n;
    @(negedge clk);
    out_ready_8 = 1'b1;
    in_valid_8  = 1'b1;
    in_data_8   = d;
    in_inject_8 = m;
    chk({tag, "_in_ready"}, 32'(in_ready_8), 32'd1);
    @(negedge clk);
    in_valid_8 = 1'b0;
    n = 1;
    while (!out_valid_8 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid_8), 32'd1);
    chk({tag, "_cw"}, 32'(out_codeword_8), 32'(ecw));
    chk({tag, "_data"}, 32'(out_data_8), 32'(d));
    chk({tag, "_syn"}, 32'(out_syndrome_8), 32'(esyn));
    chk({tag, "_single"}, 32'(out_err_single_8), 32'(es));
    chk({tag, "_double"}, 32'(out_err_double_8), 32'(ed));
    @(negedge clk);
    chk({tag, "_corr_cnt"}, 32'(corr_cnt_8), 32'(ecorr));
    chk({tag, "_uncorr_cnt"}, 32'(uncorr_cnt_8), 32'(euncorr));
  endtask

  initial begin
    vec_t v;
    int   acc, got, stale;
    logic stalled_prev;
    logic [3:0] hold_d;
    logic [7:0] hold_cw;

    //           data     inj    clr   cw     dout     syn   sgl   dbl   corr  uncorr
    vecs[0] = '{4'b1011, 8'h00, 1'b0, 8'hAA, 4'b1011, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0};
    vecs[1] = '{4'b1011, 8'h20, 1'b0, 8'h8A, 4'b1011, 3'd5, 1'b1, 1'b0, 2'd1, 2'd0};
    vecs[2] = '{4'b1011, 8'h22, 1'b0, 8'h88, 4'b1001, 3'd4, 1'b0, 1'b1, 2'd1, 2'd1};
    vecs[3] = '{4'b1011, 8'h01, 1'b0, 8'hAB, 4'b1011, 3'd0, 1'b1, 1'b0, 2'd2, 2'd1};
    vecs[4] = '{4'b1111, 8'h00, 1'b0, 8'hFF, 4'b1111, 3'd0, 1'b0, 1'b0, 2'd2, 2'd1};
    vecs[5] = '{4'b0110, 8'h80, 1'b0, 8'hE6, 4'b0110, 3'd7, 1'b1, 1'b0, 2'd3, 2'd1};
    vecs[6] = '{4'b0001, 8'h28, 1'b0, 8'h27, 4'b0010, 3'd6, 1'b0, 1'b1, 2'd3, 2'd2};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    in_data = 4'd0; in_inject = 8'd0;
    in_valid_8 = 1'b0; out_ready_8 = 1'b1; clr_cnt_8 = 1'b0;
    in_data_8 = 8'd0; in_inject_8 = 13'd0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_cw", 32'(out_codeword), 32'd0);
    chk("rst_flags", {30'd0, out_err_single, out_err_double}, 32'd0);
    chk("rst_counters", {28'd0, corr_cnt, uncorr_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // clear, then saturate the 2-bit correction counter
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    chk("clr_corr", 32'(corr_cnt), 32'd0);
    chk("clr_uncorr", 32'(uncorr_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      v = '{4'b1011, 8'h20, 1'b0, 8'h8A, 4'b1011, 3'd5, 1'b1, 1'b0,
            (i >= 2) ? 2'd3 : 2'(i + 1), 2'd0};
      run_vec(v, $sformatf("sat%0d", i));
    end
    v = '{4'b1011, 8'h20, 1'b1, 8'h8A, 4'b1011, 3'd5, 1'b1, 1'b0, 2'd0, 2'd0};
    run_vec(v, "clr_vs_inc");

    // backpressure: six beats, consumer stalled in cycles 2..8
    acc = 0; got = 0; stalled_prev = 1'b0; hold_d = 4'd0; hold_cw = 8'd0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      in_valid  = (acc < 6);
      in_data   = 4'(acc);
      in_inject = 8'h00;
      out_ready = !(cyc >= 2 && cyc <= 8);
      #1;
      if (stalled_prev) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_data", 32'(out_data), 32'(hold_d));
        chk("bp_hold_cw", 32'(out_codeword), 32'(hold_cw));
      end
      if (cyc == 8) begin
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_held_beats", 32'(acc), 32'd3);
      end
      stalled_prev = out_valid && !out_ready;
      hold_d  = out_data;
      hold_cw = out_codeword;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_beat%0d_data", got), 32'(out_data), 32'(got));
        chk($sformatf("bp_beat%0d_flags", got), {30'd0, out_err_single, out_err_double}, 32'd0);
        got++;
      end
      if (in_valid && in_ready) acc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_beats_out", 32'(got), 32'd6);

    // DATA_W=8: syndrome 13 lies beyond N=12
    run8(8'h00, 13'h0112, 13'h0112, 4'd13, 1'b0, 1'b1, 8'd0, 8'd1, "w8_syn13");
    run8(8'h00, 13'h1000, 13'h1000, 4'd12, 1'b1, 1'b0, 8'd1, 8'd1, "w8_pos12");
    run8(8'h01, 13'h0000, 13'h000F, 4'd0, 1'b0, 1'b0, 8'd1, 8'd1, "w8_clean");

    // reset with three beats in flight
    v = '{4'b1011, 8'h20, 1'b0, 8'h8A, 4'b1011, 3'd5, 1'b1, 1'b0, 2'd1, 2'd0};
    run_vec(v, "pre_rst");
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1011; in_inject = 8'h20; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_inflight_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_counters", {28'd0, corr_cnt, uncorr_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rs_stale_beats", 32'(stale), 32'd0);
    chk("rs_counters_after", {28'd0, corr_cnt, uncorr_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
